// File: rtl/axis_frame_arbiter.sv
// Two-input AXI-Stream frame arbiter: grants whole video frames round-robin,
// flushes idle mid-frame inputs so the shared datapath only sees complete frames.
module axis_frame_arbiter #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_HBITS   = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [C_IMG_HBITS-1:0]   height,
  input  logic [C_PIXEL_WIDTH-1:0] s0_axis_tdata,
  input  logic                     s0_axis_tuser,
  input  logic                     s0_axis_tlast,
  input  logic                     s0_axis_tvalid,
  output logic                     s0_axis_tready,
  input  logic [C_PIXEL_WIDTH-1:0] s1_axis_tdata,
  input  logic                     s1_axis_tuser,
  input  logic                     s1_axis_tlast,
  input  logic                     s1_axis_tvalid,
  output logic                     s1_axis_tready,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_sel,
  output logic                     busy,
  output logic                     frame_err
);

  typedef enum logic {IDLE, PASS} state_t;

  state_t                 r_state, w_next;
  logic                   r_rr_ptr, r_sel, r_frame_err, r_started;
  logic [C_IMG_HBITS-1:0] r_line_cnt, r_height;
  logic                   w_req0, w_req1, w_gnt, w_hs, w_early, w_last_line;
  logic [C_IMG_HBITS-1:0] w_cnt_base;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    m_axis_tdata   = r_sel ? s1_axis_tdata : s0_axis_tdata;
    m_axis_tuser   = r_sel ? s1_axis_tuser : s0_axis_tuser;
    m_axis_tlast   = r_sel ? s1_axis_tlast : s0_axis_tlast;
    m_axis_tvalid  = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    w_req0         = s0_axis_tvalid & s0_axis_tuser;
    w_req1         = s1_axis_tvalid & s1_axis_tuser;
    w_gnt          = (w_req0 & w_req1) ? r_rr_ptr : w_req1;
    w_hs           = 1'b0;
    w_early        = 1'b0;
    w_cnt_base     = r_line_cnt;
    w_last_line    = 1'b0;
    case (r_state)
      IDLE: begin
        // SOF pixels are held as requests; anything else is mid-frame debris
        s0_axis_tready = s0_axis_tvalid & ~s0_axis_tuser;
        s1_axis_tready = s1_axis_tvalid & ~s1_axis_tuser;
        if (w_req0 | w_req1) w_next = PASS;
      end
      PASS: begin
        m_axis_tvalid = r_sel ? s1_axis_tvalid : s0_axis_tvalid;
        if (r_sel) s1_axis_tready = m_axis_tready;
        else       s0_axis_tready = m_axis_tready;
        w_hs    = m_axis_tvalid & m_axis_tready;
        w_early = w_hs & m_axis_tuser & ((r_line_cnt != '0) | r_started);
        if (w_early) w_cnt_base = '0;
        w_last_line = w_hs & m_axis_tlast & (w_cnt_base == r_height - 1'b1);
        if (w_last_line) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= 1'b0;
      r_sel       <= 1'b0;
      r_line_cnt  <= '0;
      r_height    <= '0;
      r_started   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_early;
      if (r_state == IDLE) begin
        if (w_req0 | w_req1) begin
          r_sel      <= w_gnt;
          r_line_cnt <= '0;
          r_height   <= (height == '0) ? C_IMG_HBITS'(1) : height;
          r_started  <= 1'b0;
        end
      end else if (w_hs) begin
        r_started <= 1'b1;
        if (w_last_line)       r_rr_ptr   <= ~r_sel;
        else if (m_axis_tlast) r_line_cnt <= w_cnt_base + 1'b1;
        else                   r_line_cnt <= w_cnt_base;
      end
    end
  end

  assign m_sel     = r_sel;
  assign busy      = (r_state == PASS);
  assign frame_err = r_frame_err;

endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Shares one downstream AXI-Stream video datapath (e.g. axis_bayer_extractor) between two camera streams.
- Grants whole frames only. It locks onto an input at its start-of-frame (tuser), passes it through until the last line's tlast, then re-arbitrates round-robin.
- Non-granted inputs are stalled. Idle inputs that are mid-frame are flushed until their next SOF, so the datapath always sees complete frames.

Parameters:
- C_PIXEL_WIDTH, 8, data width of all tdata ports
- C_IMG_HBITS, 12, width of the height port and the internal line counter

Ports:
- clk  in  1  clock; all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- height  in  C_IMG_HBITS  lines per frame; sampled at grant, held in an internal register for the whole frame
- s0_axis_tdata  in  C_PIXEL_WIDTH  input 0 pixel
- s0_axis_tuser  in  1  input 0 start-of-frame
- s0_axis_tlast  in  1  input 0 end-of-line
- s0_axis_tvalid  in  1  input 0 valid
- s0_axis_tready  out  1  input 0 ready
- s1_axis_tdata/tuser/tlast/tvalid/tready  same as input 0, for input 1
- m_axis_tdata  out  C_PIXEL_WIDTH  output pixel
- m_axis_tuser  out  1  output start-of-frame
- m_axis_tlast  out  1  output end-of-line
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_sel  out  1  index of the granted/last-granted input
- busy  out  1  high while a frame is in progress (state PASS)
- frame_err  out  1  one-cycle pulse on an early SOF within a granted frame

Behaviour:
- Reset values (asynchronous): state=IDLE, rr_ptr=0, m_sel=0, line_cnt=0, busy=0, frame_err=0. Consequently m_axis_tvalid=0, s0/s1_axis_tready=0 except for the IDLE flush rule below.
- States:
  - IDLE: no output. For each input i, if sI_tvalid=1 and sI_tuser=0, assert sI_tready=1 and drop the pixel (flush). If sI_tvalid=1 and sI_tuser=1, tready=0: the pixel is held and the input raises a request.
  - PASS: the granted input g=m_sel is combinationally connected to m_axis: tdata/tuser/tlast/tvalid from sg, sg_tready=m_axis_tready. The other input's tready=0 (no flushing while busy).
- Arbitration, IDLE->PASS:
  - Registered grant: PASS is entered the cycle after the request is seen.
  - Only one input requests: grant it.
  - Both request: grant input rr_ptr.
  - On grant: m_sel<=g, line_cnt<=0, height_r<=(height==0 ? 1 : height), busy<=1.
  - The held SOF pixel is the first transfer in PASS.
- Line counting: on m_axis handshake with tlast=1, line_cnt increments.
- PASS->IDLE: on handshake with tlast=1 and line_cnt==height_r-1.
  - busy<=0, rr_ptr<=~m_sel.
  - m_sel holds its value in IDLE.
  - Zero dead cycles beyond the 1-cycle registered grant.
- Early SOF: a handshake with tuser=1 while line_cnt!=0 or a pixel of the current frame was already transferred.
  - The pixel passes through, line_cnt<=0 (the new frame restarts counting), and frame_err pulses for 1 cycle.
  - The grant is kept.
- Simultaneous tuser and tlast on one beat (1-pixel lines): treated as SOF first, then tlast counting. If height_r==1, the frame ends on that beat.
- A height change during PASS is ignored until the next grant.
- Reset asserted mid-frame: immediate return to IDLE, all outputs to reset values. Any partial frame still arriving on the inputs is flushed by the IDLE rule.
- line_cnt width is C_IMG_HBITS and never wraps, because it is bounded by height_r-1.
- Backpressure: m_axis_tready=0 stalls the granted source. No internal buffering; the block is purely combinational in the data path.

Test Plan:
- Single source. height=4, 4x4 frames on s0 only, m_tready=1. Required: 16 beats out, tuser on beat 0, tlast on beats 3/7/11/15, busy falls after beat 15, m_sel=0 throughout.
- Round-robin. Both inputs present SOF in the same cycle after reset, height=2, 3-pixel lines. Required: s0 frame fully output (6 beats), then s1 frame (6 beats), then s0 again; m_sel sequence 0,1,0; s1_tready=0 during s0's frame.
- Flush. s1 starts mid-frame at row 2 pixel 1 of a 4x4 frame while IDLE. Required: s1 beats are consumed (tready=1) with no m_axis_tvalid until s1's next tuser, after which its full 16-pixel frame appears.
- Backpressure. Random m_tready at 50% on a 4x4 frame. Required: output data sequence identical to the input (values row*16+col), no beat dropped or duplicated, sg_tready equals m_tready every cycle.
- Early SOF. tuser reasserted at row 2 col 0 of a height=4 frame. Required: frame_err pulses exactly once, and 4 more lines pass before busy drops.
- Reset mid-frame. reset pulsed after 5 beats. Required: m_axis_tvalid=0 and busy=0 asynchronously; after release, output resumes only at the next tuser.
